// File: rtl/fetch_queue.sv
// Instruction-fetch stage: single-outstanding imem request feeding a DEPTH-entry {pc,instr} FIFO.
// Define FETCH_PERF_CNT_EN to add the perf_fetched / perf_stall counters.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_valid,
  input  logic [31:0] pc,
  output logic        pc_ready,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_t;

  state_t          r_state;
  logic            r_req;
  logic [31:0]     r_addr;
  logic [31:0]     r_pc;
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [CW-1:0]   r_count;
  logic [31:0]     r_mem_pc    [DEPTH];
  logic [31:0]     r_mem_instr [DEPTH];

  logic            w_wait, w_pop, w_push, w_accept;
  logic [CW:0]     w_need;

  assign w_wait = (r_state == S_WAIT);
  assign w_pop  = if_valid && if_ready && !flush;
  assign w_push = w_wait && imem_ack && !flush;

  // Occupancy after this cycle, counting a reserved slot for the fetch in flight.
  assign w_need   = {1'b0, r_count} + (CW+1)'(w_wait) - (CW+1)'(w_pop);
  assign pc_ready = !flush && (r_state == S_IDLE || (w_wait && imem_ack)) &&
                    (w_need < (CW+1)'(DEPTH));
  assign w_accept = pc_valid && pc_ready;

  assign imem_req  = r_req;
  assign imem_addr = r_addr;
  assign if_valid  = (r_count != '0);
  assign if_pc     = r_mem_pc[r_rptr];
  assign if_instr  = r_mem_instr[r_rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_pc    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_pc    <= pc;
            r_addr  <= {pc[31:2], 2'b00};
            r_req   <= 1'b1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (flush) begin
            // Request must stay up until acked; its data is then dropped.
            if (imem_ack) begin
              r_req   <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_DISCARD;
            end
          end else if (imem_ack) begin
            if (w_accept) begin
              r_pc   <= pc;
              r_addr <= {pc[31:2], 2'b00};
            end else begin
              r_req   <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        S_DISCARD: begin
          if (imem_ack) begin
            r_req   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_pc[i]    <= '0;
        r_mem_instr[i] <= '0;
      end
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem_pc[r_wptr]    <= r_pc;
        r_mem_instr[r_wptr] <= imem_rdata;
        r_wptr              <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (w_push)                perf_fetched <= perf_fetched + 32'd1;
      if (pc_valid && !pc_ready) perf_stall   <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: reference model + {pc,instr} scoreboard, memory model with
// programmable ack latency, and directed scenario tasks.
module tb_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_valid;
  logic [31:0] pc;
  logic        pc_ready;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .pc_valid(pc_valid), .pc(pc), .pc_ready(pc_ready),
    .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .if_ready(if_ready)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // memory model
  int mem_lat;
  int mem_cnt;
  bit mem_bad;

  // reference model
  int          m_state;   // 0 idle, 1 wait, 2 discard
  int          m_count;
  bit          m_req;
  logic [31:0] m_addr;
  logic [31:0] m_inpc;
  logic [31:0] m_fetched;
  logic [31:0] m_stall;
  logic [63:0] sb[$];

  // per-cycle samples taken mid-cycle
  bit          last_acc;
  logic        s_pc_ready, s_if_valid, s_req;
  logic [31:0] s_addr;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[27:0], a[31:28]} ^ 32'h0000_0013;
  endfunction

  task automatic model_reset();
    m_state = 0; m_count = 0; m_req = 0; m_addr = '0; m_inpc = '0;
    m_fetched = '0; m_stall = '0; sb.delete();
    mem_cnt = 0; mem_bad = 0;
  endtask

  // One clock: memory responds, model predicts and is compared, then the edge.
  task automatic step();
    bit pop, push, wt, mready;
    logic [63:0] hd;
    @(negedge clk);
    if (imem_req && mem_cnt >= mem_lat) begin
      imem_ack   = 1'b1;
      imem_rdata = mem_bad ? 32'hDEAD_BEEF : instr_of(imem_addr);
      mem_cnt    = 0;
      mem_bad    = 0;
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = '0;
      if (imem_req) mem_cnt++; else mem_cnt = 0;
    end
    #1;
    s_pc_ready = pc_ready; s_if_valid = if_valid; s_req = imem_req; s_addr = imem_addr;
    wt     = (m_state == 1);
    pop    = (m_count != 0) && if_ready && !flush;
    push   = wt && imem_ack && !flush;
    mready = !flush && (m_state == 0 || (wt && imem_ack)) &&
             (m_count + (wt ? 1 : 0) - (pop ? 1 : 0) < DEPTH);
    n_cmp++;
    if (pc_ready !== mready) begin n_err++; $display("FAIL pc_ready: got %b want %b t=%0t", pc_ready, mready, $time); end
    n_cmp++;
    if (if_valid !== (m_count != 0)) begin n_err++; $display("FAIL if_valid: got %b want %b t=%0t", if_valid, m_count != 0, $time); end
    n_cmp++;
    if (imem_req !== m_req || imem_addr !== m_addr) begin
      n_err++; $display("FAIL imem: got req=%b addr=%h want req=%b addr=%h t=%0t", imem_req, imem_addr, m_req, m_addr, $time);
    end
`ifdef FETCH_PERF_CNT_EN
    n_cmp++;
    if (perf_fetched !== m_fetched || perf_stall !== m_stall) begin
      n_err++; $display("FAIL perf: got %0d/%0d want %0d/%0d", perf_fetched, perf_stall, m_fetched, m_stall);
    end
`endif
    if (pop) begin
      hd = sb.pop_front();
      n_cmp++;
      if ({if_pc, if_instr} !== hd) begin
        n_err++; $display("FAIL head: got pc=%h instr=%h want pc=%h instr=%h", if_pc, if_instr, hd[63:32], hd[31:0]);
      end
    end
    if (push) begin
      sb.push_back({m_inpc, instr_of({m_inpc[31:2], 2'b00})});
      m_fetched = m_fetched + 32'd1;
    end
    if (pc_valid && !mready) m_stall = m_stall + 32'd1;
    last_acc = pc_valid && mready;
    if (flush) begin m_count = 0; sb.delete(); end
    else m_count = m_count + (push ? 1 : 0) - (pop ? 1 : 0);
    case (m_state)
      0: if (last_acc) begin m_inpc = pc; m_addr = {pc[31:2], 2'b00}; m_req = 1; m_state = 1; end
      1: begin
        if (flush) begin
          if (imem_ack) begin m_req = 0; m_state = 0; end else m_state = 2;
        end else if (imem_ack) begin
          if (last_acc) begin m_inpc = pc; m_addr = {pc[31:2], 2'b00}; end
          else begin m_req = 0; m_state = 0; end
        end
      end
      default: if (imem_ack) begin m_req = 0; m_state = 0; end
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic idle_steps(input int n);
    pc_valid = 0; flush = 0; if_ready = 1;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic test_reset();
    rst_n = 0; pc_valid = 0; pc = '0; flush = 0; imem_ack = 0; imem_rdata = '0; if_ready = 0;
    mem_lat = 0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0) begin
      n_err++; $display("FAIL reset: req=%b addr=%h vld=%b pc=%h instr=%h", imem_req, imem_addr, if_valid, if_pc, if_instr);
    end
    model_reset();
    rst_n = 1;
  endtask

  task automatic test_stream();
    int acc = 0;
    mem_lat = 0; if_ready = 1; flush = 0;
    for (int c = 0; c < 3; c++) begin
      pc_valid = 1; pc = 32'(acc * 4);
      step();
      if (last_acc) acc++;
      if (c == 0) begin
        n_cmp++;
        if (imem_req !== 1'b1 || if_valid !== 1'b0) begin n_err++; $display("FAIL stream_c1: req=%b vld=%b want 1/0", imem_req, if_valid); end
      end
      if (c == 1) begin
        n_cmp++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0) begin n_err++; $display("FAIL stream_c2: vld=%b pc=%h want 1/0", if_valid, if_pc); end
      end
    end
    n_cmp++;
    if (acc != 3) begin n_err++; $display("FAIL stream_rate: accepted %0d want 3", acc); end
    idle_steps(4);
  endtask

  task automatic test_full();
    int acc = 0, pops = 0;
    mem_lat = 0; if_ready = 0; flush = 0;
    for (int c = 0; c < 8; c++) begin
      pc_valid = 1; pc = 32'h1000 + 32'(acc * 4);
      step();
      if (last_acc) acc++;
    end
    n_cmp++;
    if (acc != DEPTH) begin n_err++; $display("FAIL full_acc: accepted %0d want %0d", acc, DEPTH); end
    n_cmp++;
    if (s_pc_ready !== 1'b0 || imem_req !== 1'b0 || if_valid !== 1'b1) begin
      n_err++; $display("FAIL full_state: rdy=%b req=%b vld=%b want 0/0/1", s_pc_ready, imem_req, if_valid);
    end
    pc_valid = 0; if_ready = 1;
    for (int c = 0; c < 8; c++) begin
      step();
      if (s_if_valid) pops++;
    end
    n_cmp++;
    if (pops != DEPTH) begin n_err++; $display("FAIL full_drain: popped %0d want %0d", pops, DEPTH); end
    for (int c = 0; c < 3; c++) begin pc_valid = 1; pc = 32'h2000 + 32'(c * 4); step(); end
    idle_steps(5);
  endtask

  task automatic test_slow_mem();
    mem_lat = 3; if_ready = 1; flush = 0;
    pc_valid = 1; pc = 32'h10;
    step();
    pc = 32'h14;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if (s_req !== 1'b1 || s_addr !== 32'h10 || s_pc_ready !== 1'b0) begin
        n_err++; $display("FAIL slow_hold: req=%b addr=%h rdy=%b want 1/00000010/0", s_req, s_addr, s_pc_ready);
      end
    end
    step();
    n_cmp++;
    if (s_pc_ready !== 1'b1) begin n_err++; $display("FAIL slow_ack: rdy=%b want 1", s_pc_ready); end
    pc_valid = 0;
    idle_steps(8);
  endtask

  task automatic test_flush_wait();
    int k = 0;
    mem_lat = 3; if_ready = 1; flush = 0;
    pc_valid = 1; pc = 32'h20;
    step();
    pc_valid = 0;
    step();
    flush = 1; mem_bad = 1;
    step();
    flush = 0;
    n_cmp++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1) begin n_err++; $display("FAIL flush_disc: vld=%b req=%b want 0/1", if_valid, imem_req); end
    pc_valid = 1; pc = 32'h100;
    step();
    n_cmp++;
    if (s_pc_ready !== 1'b0) begin n_err++; $display("FAIL flush_rdy: rdy=%b want 0", s_pc_ready); end
    while (!last_acc && k < 10) begin
      if (!mem_bad) mem_lat = 0;
      step(); k++;
    end
    n_cmp++;
    if (!last_acc) begin n_err++; $display("FAIL flush_timeout: pc 0x100 not accepted (got 0 want 1)"); end
    pc_valid = 0;
    idle_steps(4);
  endtask

  task automatic test_flush_ack();
    mem_lat = 0; if_ready = 0; flush = 0;
    pc_valid = 1; pc = 32'h40; step();
    pc = 32'h44; step();
    pc_valid = 0; flush = 1; if_ready = 1; step();
    flush = 0;
    n_cmp++;
    if (if_valid !== 1'b0 || imem_req !== 1'b0) begin n_err++; $display("FAIL flush_ack: vld=%b req=%b want 0/0", if_valid, imem_req); end
    step();
    n_cmp++;
    if (s_pc_ready !== 1'b1) begin n_err++; $display("FAIL flush_ack_rdy: rdy=%b want 1", s_pc_ready); end
    idle_steps(2);
  endtask

  task automatic test_unaligned();
    mem_lat = 0; if_ready = 0; flush = 0;
    pc_valid = 1; pc = 32'h6; step();
    pc_valid = 0;
    n_cmp++;
    if (imem_addr !== 32'h4) begin n_err++; $display("FAIL unal_addr: got %h want 00000004", imem_addr); end
    step();
    n_cmp++;
    if (if_valid !== 1'b1 || if_pc !== 32'h6 || if_instr !== instr_of(32'h4)) begin
      n_err++; $display("FAIL unal_head: vld=%b pc=%h instr=%h want 1/00000006/%h", if_valid, if_pc, if_instr, instr_of(32'h4));
    end
    idle_steps(3);
  endtask

  task automatic test_reset_mid();
    mem_lat = 5; if_ready = 1; flush = 0;
    pc_valid = 1; pc = 32'h200; step();
    pc_valid = 0; step();
    rst_n = 0;
    #1;
    n_cmp++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0) begin n_err++; $display("FAIL reset_mid: req=%b vld=%b want 0/0", imem_req, if_valid); end
    @(posedge clk); #1;
    model_reset();
    rst_n = 1;
    mem_lat = 0;
    pc_valid = 1; pc = 32'h300; step();
    idle_steps(3);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_slow_mem();
    test_flush_wait();
    test_flush_ack();
    test_unaligned();
    test_reset_mid();
    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL sb_empty: %0d entries left want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
